alu_seq: RTL

Parametrised, handshaked successor to the combinational 8-bit ALU: WIDTH-bit operands, registered Result/NZCV, valid/ready on input and output, plus an optional iterative multiplier. Sits between the CPU decode/operand-fetch stage and writeback. Downstream stalls hold the result stable. Single-cycle ops complete in 1 cycle, MUL in WIDTH+1 cycles.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and NZCV flag helpers for alu_seq.
// Build option ALU_MUL_EN selects the iterative multiplier.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operand bus and result bus of alu_seq.
// master = issuing stage, slave = ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       OP_Code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [3:0]       NZCV;
  logic             out_err;

  modport master (
    output in_valid, A, B, OP_Code, out_ready,
    input  in_ready, out_valid, Result, NZCV, out_err
  );

  modport slave (
    input  in_valid, A, B, OP_Code, out_ready,
    output in_ready, out_valid, Result, NZCV, out_err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle.
// product is the value after the current step; valid when done is high.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;

  // High half accumulates, low half shifts the multiplier out LSB first.
  always_comb begin
    addend  = p[0] ? mcand : '0;
    sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    product = {sum, p[WIDTH-1:1]};
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // Load operands on start, then step once per cycle for WIDTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      p     <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      p   <= product;
      cnt <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered Result/NZCV.
// Define ALU_MUL_EN to build the iterative MUL; otherwise MUL reports out_err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e       state;
  alu_op_e          op;
  logic             accept;
  logic             take_mul;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flags_q;
  logic             valid_q;
  logic             err_q;

  logic [WIDTH-1:0] res_c;
  logic [3:0]       flags_c;
  logic             c_c;
  logic             v_c;
  logic             err_c;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [SW-1:0]    amt;

  assign op       = alu_op_e'(bus.OP_Code);
  assign amt      = bus.B[SW-1:0];
  assign bus.in_ready =
    (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.out_valid = valid_q;
  assign bus.Result    = res_q;
  assign bus.NZCV      = flags_q;
  assign bus.out_err   = err_q;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;
  logic [3:0]         mul_flags;
  logic               mul_busy;
  logic               mul_done;

  assign take_mul = (op == ALU_MUL);
  assign mul_res  = mul_prod[WIDTH-1:0];
  assign mul_flags = pack_flags(
    mul_res[WIDTH-1],
    mul_res == '0,
    |mul_prod[2*WIDTH-1:WIDTH],
    1'b0
  );

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && take_mul),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign take_mul = 1'b0;
`endif

  // Single-cycle datapath; carries come from the WIDTH+1-bit results.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    sum_w = {1'b0, bus.A} + {1'b0, bus.B};
    dif_w = {1'b0, bus.A} - {1'b0, bus.B};
    shl_w = {1'b0, bus.A} << amt;
    shr_w = {bus.A, 1'b0} >> amt;
    unique case (1'b1)
      op == ALU_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      op == ALU_SUB: begin
        res_c = dif_w[WIDTH-1:0];
        c_c   = ~dif_w[WIDTH];
        v_c   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                (dif_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      op == ALU_AND: res_c = bus.A & bus.B;
      op == ALU_OR:  res_c = bus.A | bus.B;
      op == ALU_XOR: res_c = bus.A ^ bus.B;
      op == ALU_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      op == ALU_SHR: begin
        res_c = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      op == ALU_MUL: begin
`ifdef ALU_MUL_EN
        res_c = '0;
`else
        err_c = 1'b1;
`endif
      end
      default: res_c = '0;
    endcase
    flags_c = pack_flags(res_c[WIDTH-1], res_c == '0, c_c, v_c);
  end

  // Control FSM; all result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (take_mul) begin
              state   <= S_MUL;
              valid_q <= 1'b0;
            end else begin
              state   <= S_DONE;
              valid_q <= 1'b1;
              res_q   <= res_c;
              flags_q <= flags_c;
              err_q   <= err_c;
            end
          end else if ((state == S_DONE) && bus.out_ready) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          if (mul_done) begin
            state   <= S_DONE;
            valid_q <= 1'b1;
            res_q   <= mul_res;
            flags_q <= mul_flags;
            err_q   <= 1'b0;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
